seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed source for the watch display: holds a character code per digit and scans the digits one at a time, presenting each digit's `value`/`mode` pair to the seven-segment decoder together with a one-hot digit enable. Software-side logic (watch controller FSM) loads a shadow buffer through a write port and commits it atomically; the committed contents switch only on a frame boundary, so no partially updated text is ever shown. Per-digit blinking blanks selected digits with the alphabet SPACE code.

## Interface
- `DIGITS`, 4: number of display digits (2..8).
- `SCAN_DIV`, 1000: clock cycles each digit stays enabled (>= 2).
- `BLINK_FRAMES`, 64: frames per blink half-period (>= 1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one shadow entry this cycle.
- `wr_idx`  in  clog2(DIGITS)  shadow entry index; 0 is digit_en bit 0; out-of-range index is ignored.
- `wr_value`  in  4  character/number code.
- `wr_mode`  in  1  0 = NUMBER, 1 = ALPHABET.
- `commit`  in  1  request copy of shadow to active at the next frame boundary.
- `blink_mask`  in  DIGITS  digit i blanks during blink-off phase when bit i = 1.
- `value_out`  out  4  code of the digit currently enabled.
- `mode_out`  out  1  mode of the digit currently enabled.
- `digit_en`  out  DIGITS  one-hot active-high digit select.
- `frame_start`  out  1  one-cycle pulse in the first cycle of digit 0.
- `commit_ack`  out  1  one-cycle pulse in the cycle the new active contents are first shown.
- `pending`  out  1  commit accepted, not yet applied.

## Operation
- Storage: shadow[DIGITS] and active[DIGITS], each {value[3:0], mode}. Blank entry = {4'b0000, 1} (ALPHABET SPACE).
- Write: `wr_en` writes shadow[wr_idx] on the edge; never touches active.
- Scan: slot counter 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and digit index advances; digit index wraps DIGITS-1 -> 0 (frame boundary edge).
- Commit: `commit` sets `pending`. On a frame boundary edge with `pending` = 1: active <= shadow as it stands before that edge (a write in the same cycle is excluded), `pending` <= 0, `commit_ack` pulses for the following cycle. `commit` while pending: no extra effect. `commit` in the boundary cycle itself with `pending` = 0: sets `pending`, applied at the next boundary.
- Blink: frame counter 0..BLINK_FRAMES-1 increments on each frame boundary; on wrap, blink phase toggles. Phase 0 = on, 1 = off. In phase off, digits with mask bit set output the blank entry; `blink_mask` is sampled together with the digit index.
- Outputs registered: `value_out`, `mode_out`, `digit_en` change together on the edge the digit index changes; exactly one `digit_en` bit set at all times after reset.
- Reset: shadow and active all blank, slot = 0, digit index = 0, frame counter = 0, phase = on, pending = 0. Outputs in the cycle after reset: `digit_en` = 1, `value_out` = 0, `mode_out` = 1, `frame_start` = 1, `commit_ack` = 0, `pending` = 0. Reset mid-commit discards the request and the shadow contents.

## Timing
- Each digit enabled for exactly SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles.
- Write-to-display latency: commit applied at the first frame boundary strictly after the cycle in which `pending` is seen set; worst case one frame plus one cycle.
- `frame_start` and `commit_ack` coincide with the first cycle of digit 0.
- Blink phase changes only at frame boundaries; half-period = BLINK_FRAMES frames.
- No stall or back-pressure; writes are accepted every cycle.

## Test plan
- Reset (DIGITS=4, SCAN_DIV=4): after release, `digit_en` sequence 0001 x4 cycles, 0010, 0100, 1000, back to 0001; `frame_start` every 16 cycles; all outputs value 0, mode 1.
- Load "1234" NUMBER into shadow, commit mid-frame: display unchanged until next boundary; then digits 0..3 show 1,2,3,4 mode 0; `commit_ack` one pulse; `pending` high 1 cycle after commit until boundary.
- Write digit 0 = 9 in boundary cycle of a pending commit: active digit 0 shows old shadow value; 9 appears only after a second commit.
- Commit asserted exactly in the boundary cycle with pending = 0: applied one full frame later (16 cycles), not immediately.
- BLINK_FRAMES=2, blink_mask=0b0101: digits 0 and 2 show {0,1} during frames 2-3, 6-7, ...; digits 1 and 3 never blank.
- Reset asserted with pending = 1: after reset pending = 0, no `commit_ack`, all digits blank.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed digit source for the watch display. A shadow buffer is
//   loaded one entry at a time and committed atomically into the active
//   buffer on a frame boundary. The active buffer is scanned one digit at a
//   time, and selected digits are blanked during the blink-off phase.
//
// Ports
//   clk, reset    : system clock, synchronous active-high reset
//   wr_en/wr_idx  : write shadow[wr_idx] <= {wr_value, wr_mode}
//   wr_value      : 4-bit character / number code
//   wr_mode       : 0 = NUMBER, 1 = ALPHABET
//   commit        : request shadow -> active copy at the next frame boundary
//   blink_mask    : per-digit blink enable
//   value_out     : code of the enabled digit
//   mode_out      : mode of the enabled digit
//   digit_en      : one-hot digit select
//   frame_start   : pulse in the first cycle of digit 0
//   commit_ack    : pulse in the first cycle that shows new active contents
//   pending       : commit accepted but not yet applied
module seven_seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DIGITS)-1:0]  wr_idx,
  input  logic [3:0]                 wr_value,
  input  logic                       wr_mode,
  input  logic                       commit,
  input  logic [DIGITS-1:0]          blink_mask,
  output logic [3:0]                 value_out,
  output logic                       mode_out,
  output logic [DIGITS-1:0]          digit_en,
  output logic                       frame_start,
  output logic                       commit_ack,
  output logic                       pending
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]  LAST_DIG   = IDX_W'(DIGITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [FR_W-1:0]   LAST_FRAME = FR_W'(BLINK_FRAMES - 1);

  // Entry layout {value[3:0], mode}; blank is the ALPHABET SPACE code.
  localparam logic [4:0] BLANK = 5'b0000_1;

  // Replace an entry by the blank code when its digit is blinked off.
  function automatic logic [4:0] blink_gate(input logic [4:0] entry,
                                            input logic       phase_off,
                                            input logic       masked);
    return (phase_off && masked) ? BLANK : entry;
  endfunction

  logic [4:0]              shadow_q [DIGITS];
  logic [4:0]              shadow_d [DIGITS];
  logic [4:0]              active_q [DIGITS];
  logic [4:0]              active_d [DIGITS];
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [IDX_W-1:0]        dig_q, dig_d;
  logic [FR_W-1:0]         frame_q, frame_d;
  logic                    phase_q, phase_d;
  logic                    pending_q, pending_d;
  logic [3:0]              value_out_q, value_out_d;
  logic                    mode_out_q, mode_out_d;
  logic [DIGITS-1:0]       digit_en_q, digit_en_d;
  logic                    frame_start_q, frame_start_d;
  logic                    commit_ack_q, commit_ack_d;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic [4:0]              shown;

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    slot_d        = slot_q + SLOT_W'(1);
    dig_d         = dig_q;
    frame_d       = frame_q;
    phase_d       = phase_q;
    pending_d     = pending_q;
    value_out_d   = value_out_q;
    mode_out_d    = mode_out_q;
    digit_en_d    = digit_en_q;
    frame_start_d = 1'b0;
    commit_ack_d  = 1'b0;
    shown         = BLANK;

    slot_wrap  = (slot_q == LAST_SLOT);
    frame_wrap = slot_wrap && (dig_q == LAST_DIG);

    if (wr_en && (int'(wr_idx) < DIGITS)) begin
      shadow_d[wr_idx] = {wr_value, wr_mode};
    end

    if (commit) begin
      pending_d = 1'b1;
    end

    if (slot_wrap) begin
      slot_d = '0;
      dig_d  = frame_wrap ? '0 : dig_q + IDX_W'(1);
    end

    if (frame_wrap) begin
      frame_start_d = 1'b1;
      if (frame_q == LAST_FRAME) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FR_W'(1);
      end
      // The copy uses the shadow as registered, so a write in this same
      // cycle only lands in the shadow and waits for the next commit.
      if (pending_q) begin
        active_d     = shadow_q;
        pending_d    = 1'b0;
        commit_ack_d = 1'b1;
      end
    end

    // Outputs are loaded for the digit being entered, from the post-commit
    // contents and post-toggle blink phase, so they move with digit_en.
    if (slot_wrap) begin
      shown       = blink_gate(active_d[dig_d], phase_d, blink_mask[dig_d]);
      value_out_d = shown[4:1];
      mode_out_d  = shown[0];
      digit_en_d  = DIGITS'(1) << dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= BLANK;
        active_q[i] <= BLANK;
      end
      slot_q        <= '0;
      dig_q         <= '0;
      frame_q       <= '0;
      phase_q       <= 1'b0;
      pending_q     <= 1'b0;
      value_out_q   <= BLANK[4:1];
      mode_out_q    <= BLANK[0];
      digit_en_q    <= DIGITS'(1);
      frame_start_q <= 1'b1;
      commit_ack_q  <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      slot_q        <= slot_d;
      dig_q         <= dig_d;
      frame_q       <= frame_d;
      phase_q       <= phase_d;
      pending_q     <= pending_d;
      value_out_q   <= value_out_d;
      mode_out_q    <= mode_out_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
      commit_ack_q  <= commit_ack_d;
    end
  end

  assign value_out   = value_out_q;
  assign mode_out    = mode_out_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;
  assign commit_ack  = commit_ack_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
// The reference model tracks time since reset and derives the digit,
// frame and blink phase from it arithmetically; buffers and the pending
// flag follow the commit/write rules at each clock edge.
module tb_seven_seg_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [3:0]  wr_value = '0;
  logic        wr_mode = 1'b0;
  logic        commit = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  value_out;
  logic        mode_out;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic        commit_ack;
  logic        pending;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_value(wr_value), .wr_mode(wr_mode), .commit(commit),
    .blink_mask(blink_mask), .value_out(value_out), .mode_out(mode_out),
    .digit_en(digit_en), .frame_start(frame_start),
    .commit_ack(commit_ack), .pending(pending)
  );

  int nchk  = 0;
  int nfail = 0;

  // Reference model state
  logic [4:0] m_sh  [DIGITS];
  logic [4:0] m_act [DIGITS];
  bit         m_pend = 0;
  bit         m_ack  = 0;
  int         t      = 0;
  logic [3:0] m_mask = '0;

  logic [11:0] observed;
  assign observed = {digit_en, value_out, mode_out, frame_start, commit_ack, pending};

  // {digit_en, value, mode, frame_start, commit_ack, pending}
  function automatic logic [11:0] model_out();
    int         d   = (t / SCAN_DIV) % DIGITS;
    int         fr  = t / FRAME;
    bit         off = ((fr / BLINK_FRAMES) % 2) == 1;
    logic [4:0] e   = (off && m_mask[d]) ? 5'b00001 : m_act[d];
    logic [3:0] en  = 4'(1 << d);
    bit         fs  = (t % FRAME) == 0;
    return {en, e, fs, m_ack, m_pend};
  endfunction

  // One clock edge: captures the driven inputs, advances the model, then
  // leaves the bench 1 time unit after the edge for sampling.
  task automatic step();
    logic       c_rst  = reset;
    logic       c_we   = wr_en;
    logic [1:0] c_idx  = wr_idx;
    logic [4:0] c_ent  = {wr_value, wr_mode};
    logic       c_cm   = commit;
    logic [3:0] c_mask = blink_mask;
    bit         bnd, app;
    @(posedge clk);
    if (c_rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_sh[i]  = 5'b00001;
        m_act[i] = 5'b00001;
      end
      m_pend = 0; m_ack = 0; t = 0; m_mask = '0;
    end else begin
      bnd = (t % FRAME) == FRAME - 1;
      app = bnd && m_pend;
      if (c_cm) m_pend = 1;
      if (app) begin
        for (int i = 0; i < DIGITS; i++) m_act[i] = m_sh[i];
        m_pend = 0;
      end
      if (c_we) m_sh[c_idx] = c_ent;
      if (((t + 1) % SCAN_DIV) == 0) m_mask = c_mask;
      m_ack = app;
      t++;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); blink_mask = '0;
    step(); step();
    nchk++;
    if (digit_en !== 4'b0001 || value_out !== 4'd0 || mode_out !== 1'b1 ||
        frame_start !== 1'b1 || commit_ack !== 1'b0 || pending !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state got en=%b val=%0d mode=%b fs=%b ack=%b pend=%b want en=0001 val=0 mode=1 fs=1 ack=0 pend=0",
               digit_en, value_out, mode_out, frame_start, commit_ack, pending);
    end
    reset = 1'b0;
    for (int k = 0; k < 2 * FRAME + 8; k++) begin
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL reset_scan t=%0d got %h want %h", t, observed, model_out());
      end
    end
  endtask

  task automatic test_commit();
    int acks = 0;
    for (int k = 0; k < FRAME && (t % FRAME) != 5; k++) step();
    for (int i = 0; i < DIGITS; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_value = 4'(i + 1); wr_mode = 1'b0;
      step();
    end
    wr_en = 1'b0; commit = 1'b1;
    step();
    commit = 1'b0;
    nchk++;
    if (pending !== 1'b1) begin
      nfail++; $display("FAIL commit_pending got %b want 1", pending);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL commit_cycle t=%0d got %h want %h", t, observed, model_out());
      end
      if (commit_ack === 1'b1) begin
        acks++;
        nchk++;
        if (digit_en !== 4'b0001 || value_out !== 4'd1 || mode_out !== 1'b0) begin
          nfail++;
          $display("FAIL commit_first_digit got en=%b val=%0d mode=%b want en=0001 val=1 mode=0",
                   digit_en, value_out, mode_out);
        end
      end
    end
    nchk++;
    if (acks != 1) begin
      nfail++; $display("FAIL commit_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_write_in_boundary();
    bit seen = 0;
    commit = 1'b1; step(); commit = 1'b0;
    for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) step();
    wr_en = 1'b1; wr_idx = 2'd0; wr_value = 4'd9; wr_mode = 1'b0;
    step();
    wr_en = 1'b0;
    nchk++;
    if (commit_ack !== 1'b1 || value_out !== 4'd1) begin
      nfail++;
      $display("FAIL boundary_write_excluded got ack=%b val=%0d want ack=1 val=1", commit_ack, value_out);
    end
    for (int k = 0; k < 4; k++) step();
    commit = 1'b1; step(); commit = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL boundary_write_cycle t=%0d got %h want %h", t, observed, model_out());
      end
      if (commit_ack === 1'b1) begin
        seen = 1;
        nchk++;
        if (value_out !== 4'd9) begin
          nfail++; $display("FAIL second_commit_value got %0d want 9", value_out);
        end
      end
    end
    nchk++;
    if (!seen) begin
      nfail++; $display("FAIL second_commit_ack got none want 1");
    end
  endtask

  task automatic test_commit_at_boundary();
    int waited = 0;
    bit got = 0;
    for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) step();
    commit = 1'b1; step(); commit = 1'b0;
    nchk++;
    if (pending !== 1'b1 || commit_ack !== 1'b0 || frame_start !== 1'b1) begin
      nfail++;
      $display("FAIL boundary_commit_deferred got pend=%b ack=%b fs=%b want pend=1 ack=0 fs=1",
               pending, commit_ack, frame_start);
    end
    while (!got && waited < 3 * FRAME) begin
      step();
      waited++;
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL boundary_commit_cycle t=%0d got %h want %h", t, observed, model_out());
      end
      got = (commit_ack === 1'b1);
    end
    nchk++;
    if (!got || waited != FRAME) begin
      nfail++;
      $display("FAIL boundary_commit_latency got %0d cycles (ack seen %0d) want %0d", waited, got, FRAME);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      wr_en    = 1'($urandom % 2);
      wr_idx   = 2'($urandom % 4);
      wr_value = 4'($urandom % 16);
      wr_mode  = 1'($urandom % 2);
      commit   = (($urandom % 8) == 0);
      if (($urandom % 16) == 0) blink_mask = 4'($urandom % 16);
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL random t=%0d got %h want %h", t, observed, model_out());
      end
    end
    idle();
  endtask

  task automatic test_blink();
    int  fr, d;
    bit  is_blank, want;
    blink_mask = 4'b0101;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_value = 4'($urandom_range(15, 1)); wr_mode = 1'b0;
      step();
    end
    wr_en = 1'b0; commit = 1'b1; step(); commit = 1'b0;
    while (t < 8 * FRAME) begin
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL blink_cycle t=%0d got %h want %h", t, observed, model_out());
      end
      fr = t / FRAME;
      d  = (t / SCAN_DIV) % DIGITS;
      if (fr >= 1) begin
        is_blank = (value_out === 4'd0) && (mode_out === 1'b1);
        want     = blink_mask[d] && ((fr % 4) >= 2);
        nchk++;
        if (is_blank !== want) begin
          nfail++;
          $display("FAIL blink_phase frame=%0d digit=%0d got blank=%0d want %0d", fr, d, is_blank, want);
        end
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_reset_pending();
    for (int k = 0; k < FRAME && (t % FRAME) != 3; k++) step();
    wr_en = 1'b1; wr_idx = 2'd2; wr_value = 4'd7; wr_mode = 1'b0; step();
    wr_en = 1'b0; commit = 1'b1; step(); commit = 1'b0;
    step();
    nchk++;
    if (pending !== 1'b1) begin
      nfail++; $display("FAIL pre_reset_pending got %b want 1", pending);
    end
    reset = 1'b1; step(); reset = 1'b0;
    nchk++;
    if (pending !== 1'b0) begin
      nfail++; $display("FAIL reset_pending_cleared got %b want 0", pending);
    end
    for (int k = 0; k < FRAME + 4; k++) begin
      step();
      nchk++;
      if (commit_ack !== 1'b0 || value_out !== 4'd0 || mode_out !== 1'b1) begin
        nfail++;
        $display("FAIL reset_discard t=%0d got ack=%b val=%0d mode=%b want ack=0 val=0 mode=1",
                 t, commit_ack, value_out, mode_out);
      end
    end
    commit = 1'b1; step(); commit = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      nchk++;
      if (observed !== model_out()) begin
        nfail++;
        $display("FAIL reset_shadow_cleared t=%0d got %h want %h", t, observed, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_write_in_boundary();
    test_commit_at_boundary();
    test_random();
    test_blink();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
